// File: rtl/reaction_game_pkg.sv
// Shared definitions for the reaction game: FSM states, result width and
// the pseudo-random delay generator.
package reaction_game_pkg;

    localparam int unsigned RESULT_W  = 14;
    localparam int unsigned LFSR_W    = 16;

    // x^16 + x^14 + x^13 + x^11 + 1, maximal length, so a non-zero seed never reaches zero
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ARMED = 3'd2,
        ST_DONE  = 3'd3,
        ST_FALSE = 3'd4
    } game_state_t;

    // One Fibonacci step: shift toward the MSB, feedback enters bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Raw active-low pushbutton -> synchronised one-clk press pulse.
// The pulse is registered and appears three clk edges after the pin falls.
module key_sync_edge
    import reaction_game_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // Two-flop synchroniser, history flop, and registered falling-edge detect.
    // Flops reset to the released level so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
            press     <= 1'b0;
        end else begin
            sync_1    <= key_n;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            press     <= sync_prev & ~sync_2;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game: random pre-light delay, then counts ms until the
// player presses react. Flags false starts and timeouts.
module reaction_timer
    import reaction_game_pkg::*;
#(
    parameter int unsigned MIN_WAIT_MS = 1000,
    parameter int unsigned MAX_MS      = 9999,
    parameter int unsigned RAND_BITS   = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_ms,
    input  logic                key_start_n,
    input  logic                key_react_n,
    output logic                led_go,
    output logic [RESULT_W-1:0] reaction_ms,
    output logic                result_valid,
    output logic                false_start,
    output logic                timeout,
    output logic                busy
);

    // Wide enough for MIN_WAIT_MS + 2^RAND_BITS - 1
    localparam int unsigned WAIT_W = $clog2(MIN_WAIT_MS + (32'd1 << RAND_BITS));

    localparam logic [RESULT_W-1:0] MAX_CNT    = RESULT_W'(MAX_MS);
    localparam logic [RESULT_W-1:0] MAX_CNT_M1 = RESULT_W'(MAX_MS - 1);
    localparam logic [WAIT_W-1:0]   MIN_WAIT   = WAIT_W'(MIN_WAIT_MS);

    logic               start_ev;
    logic               react_ev;
    logic               ms_q1;
    logic               ms_q2;
    logic               ms_primed;
    logic               ms_tick;
    logic [LFSR_W-1:0]  lfsr;
    game_state_t        state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [RESULT_W-1:0] ms_cnt;

    key_sync_edge u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_start_n),
        .press (start_ev)
    );

    key_sync_edge u_react_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_react_n),
        .press (react_ev)
    );

    // Register clk_ms; the first sample after reset loads both stages so a
    // high clk_ms at reset release is not seen as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_q1     <= 1'b0;
            ms_q2     <= 1'b0;
            ms_primed <= 1'b0;
        end else if (!ms_primed) begin
            ms_q1     <= clk_ms;
            ms_q2     <= clk_ms;
            ms_primed <= 1'b1;
        end else begin
            ms_q1     <= clk_ms;
            ms_q2     <= ms_q1;
        end
    end

    assign ms_tick = ms_q1 & ~ms_q2;

    // Free-running delay randomiser, advances every clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Game FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            ms_cnt       <= '0;
            led_go       <= 1'b0;
            reaction_ms  <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FALSE: begin
                    if (start_ev) begin
                        state        <= ST_WAIT;
                        wait_cnt     <= MIN_WAIT + WAIT_W'(lfsr[RAND_BITS-1:0]);
                        ms_cnt       <= '0;
                        led_go       <= 1'b0;
                        reaction_ms  <= '0;
                        result_valid <= 1'b0;
                        false_start  <= 1'b0;
                        timeout      <= 1'b0;
                        busy         <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    // A press on the same clk as the expiring tick is still a false start
                    if (react_ev) begin
                        state       <= ST_FALSE;
                        false_start <= 1'b1;
                        led_go      <= 1'b0;
                        busy        <= 1'b0;
                        wait_cnt    <= '0;
                    end else if (ms_tick) begin
                        if (wait_cnt <= WAIT_W'(1)) begin
                            state    <= ST_ARMED;
                            led_go   <= 1'b1;
                            ms_cnt   <= '0;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt - WAIT_W'(1);
                        end
                    end
                end

                ST_ARMED: begin
                    if (react_ev) begin
                        state        <= ST_DONE;
                        reaction_ms  <= ms_tick ? ms_cnt + RESULT_W'(1) : ms_cnt;
                        result_valid <= 1'b1;
                        led_go       <= 1'b0;
                        busy         <= 1'b0;
                    end else if (ms_tick) begin
                        if (ms_cnt >= MAX_CNT_M1) begin
                            state        <= ST_DONE;
                            ms_cnt       <= MAX_CNT;
                            reaction_ms  <= MAX_CNT;
                            timeout      <= 1'b1;
                            result_valid <= 1'b1;
                            led_go       <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            ms_cnt <= ms_cnt + RESULT_W'(1);
                        end
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    led_go <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer. clk_ms comes from a divide-by-20 counter,
// and every key press is aligned to a divider phase so tick coincidence is exact.
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_ms;
    logic        key_start_n = 1'b1;
    logic        key_react_n = 1'b1;
    logic        led_go;
    logic [13:0] reaction_ms;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
    logic        busy;

    logic [4:0]  divcnt = '0;
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned d;

    reaction_timer #(
        .MIN_WAIT_MS (3),
        .MAX_MS      (20),
        .RAND_BITS   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_ms       (clk_ms),
        .key_start_n  (key_start_n),
        .key_react_n  (key_react_n),
        .led_go       (led_go),
        .reaction_ms  (reaction_ms),
        .result_valid (result_valid),
        .false_start  (false_start),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    // 1 kHz divider stand-in: 20 clk period, high for phases 10..19
    always @(posedge clk) divcnt <= (divcnt == 5'd19) ? 5'd0 : divcnt + 5'd1;
    assign clk_ms = (divcnt >= 5'd10);

    // Reference LFSR; m_prev holds the value present before the latest edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk14(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to the negedge following the edge that set divcnt to v
    task automatic wait_div(input logic [4:0] v);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (divcnt == v) found = 1'b1;
        end
        if (!found) begin
            total_cnt++;
            $error("FAIL wait_div: divider phase %0d not seen within 40 clk", v);
        end
    endtask

    // Start pressed at phase 2 is consumed at phase 6; returns the expected delay in ticks
    task automatic do_start(output int unsigned delay);
        wait_div(5'd2);
        key_start_n = 1'b0;
        wait_div(5'd6);
        key_start_n = 1'b1;
        delay = 32'd3 + {30'd0, m_prev[1:0]};
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        chk1("rst_led_go", led_go, 1'b0);
        chk14("rst_reaction_ms", reaction_ms, 14'd0);
        chk1("rst_result_valid", result_valid, 1'b0);
        chk1("rst_false_start", false_start, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_led_go", led_go, 1'b0);

        // ---------------- normal reaction of 5 ms, extra starts ignored ----------------
        do_start(d);
        chk1("a_busy_after_start", busy, 1'b1);
        chk1("a_led_off_in_wait", led_go, 1'b0);
        wait_div(5'd14);
        key_start_n = 1'b0;
        wait_div(5'd18);
        key_start_n = 1'b1;
        chk1("a_wait_restart_ignored_led", led_go, 1'b0);
        for (int unsigned k = 2; k <= d; k++) begin
            wait_div(5'd12);
            chk1("a_led_at_tick", led_go, (k == d));
        end
        wait_div(5'd14);
        key_start_n = 1'b0;
        wait_div(5'd18);
        key_start_n = 1'b1;
        chk1("a_armed_restart_ignored_led", led_go, 1'b1);
        chk1("a_armed_busy", busy, 1'b1);
        repeat (5) wait_div(5'd12);
        wait_div(5'd14);
        key_react_n = 1'b0;
        wait_div(5'd18);
        key_react_n = 1'b1;
        wait_div(5'd19);
        chk14("a_reaction_ms", reaction_ms, 14'd5);
        chk1("a_result_valid", result_valid, 1'b1);
        chk1("a_false_start", false_start, 1'b0);
        chk1("a_timeout", timeout, 1'b0);
        chk1("a_led_off", led_go, 1'b0);
        chk1("a_busy_off", busy, 1'b0);
        // react in DONE is ignored and the result holds
        wait_div(5'd0);
        key_react_n = 1'b0;
        wait_div(5'd5);
        key_react_n = 1'b1;
        repeat (10) @(negedge clk);
        chk14("a_hold_reaction_ms", reaction_ms, 14'd5);
        chk1("a_hold_result_valid", result_valid, 1'b1);

        // ---------------- restart from DONE, react on the expiring tick ----------------
        do_start(d);
        chk1("b_restart_busy", busy, 1'b1);
        chk1("b_restart_valid_clr", result_valid, 1'b0);
        chk14("b_restart_ms_clr", reaction_ms, 14'd0);
        repeat (d - 1) wait_div(5'd0);
        wait_div(5'd8);
        key_react_n = 1'b0;
        wait_div(5'd12);
        chk1("b_false_start", false_start, 1'b1);
        chk1("b_led_off", led_go, 1'b0);
        chk1("b_result_valid", result_valid, 1'b0);
        chk1("b_busy_off", busy, 1'b0);
        wait_div(5'd14);
        key_react_n = 1'b1;

        // ---------------- plain false start mid-wait ----------------
        do_start(d);
        chk1("d_false_clr", false_start, 1'b0);
        wait_div(5'd14);
        key_react_n = 1'b0;
        wait_div(5'd18);
        key_react_n = 1'b1;
        chk1("d_false_start", false_start, 1'b1);
        repeat (8) wait_div(5'd13);
        chk1("d_led_never", led_go, 1'b0);
        chk1("d_result_valid", result_valid, 1'b0);
        chk1("d_false_hold", false_start, 1'b1);

        // ---------------- react coincident with the tick taking ms_cnt 7 -> 8 ----------------
        do_start(d);
        repeat (d - 1) wait_div(5'd0);
        wait_div(5'd13);
        chk1("c_led_on", led_go, 1'b1);
        repeat (8) wait_div(5'd0);
        wait_div(5'd8);
        key_react_n = 1'b0;
        wait_div(5'd12);
        chk14("c_reaction_ms", reaction_ms, 14'd8);
        chk1("c_result_valid", result_valid, 1'b1);
        chk1("c_timeout", timeout, 1'b0);
        chk1("c_led_off", led_go, 1'b0);
        wait_div(5'd13);
        key_react_n = 1'b1;

        // ---------------- timeout at MAX_MS ----------------
        do_start(d);
        repeat (d - 1) wait_div(5'd0);
        wait_div(5'd13);
        chk1("e_led_on", led_go, 1'b1);
        repeat (19) wait_div(5'd0);
        wait_div(5'd13);
        chk1("e_led_before_max", led_go, 1'b1);
        chk1("e_no_timeout_yet", timeout, 1'b0);
        wait_div(5'd0);
        wait_div(5'd13);
        chk14("e_reaction_ms", reaction_ms, 14'd20);
        chk1("e_timeout", timeout, 1'b1);
        chk1("e_result_valid", result_valid, 1'b1);
        chk1("e_led_off", led_go, 1'b0);

        // ---------------- reset while armed ----------------
        do_start(d);
        repeat (d - 1) wait_div(5'd0);
        wait_div(5'd13);
        chk1("f_led_on", led_go, 1'b1);
        wait_div(5'd16);
        rst_n = 1'b0;
        #1;
        chk1("f_rst_led", led_go, 1'b0);
        chk1("f_rst_busy", busy, 1'b0);
        chk14("f_rst_reaction_ms", reaction_ms, 14'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) wait_div(5'd13);
        chk1("f_led_stays_off", led_go, 1'b0);
        chk1("f_busy_stays_off", busy, 1'b0);
        chk1("f_valid_off", result_valid, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
